// File: rtl/jrb8_seg7_display.sv
// jrb8 seven-segment output stage.
// Captures each OUT value, converts it to decimal digits (iterative
// double-dabble) or two hex nibbles, then cycles the digits on a single
// 7-segment display with blank gaps between them. A single-entry pending
// register holds the most recent value written while the display is busy;
// it is picked up at the next digit boundary.
module jrb8_seg7_display #(
  parameter logic [23:0] DIGIT_CYCLES = 24'd1_000_000,
  parameter logic [23:0] GAP_CYCLES   = 24'd250_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_out_valid,
  input  logic [7:0] i_out_data,
  input  logic       i_hex_mode,
  output logic [6:0] o_segments,
  output logic       o_dp,
  output logic       o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_SHOW, S_GAP} state_t;

  state_t      r_state;
  logic [23:0] r_cnt;
  logic [7:0]  r_value;
  logic        r_hex;
  logic [7:0]  r_shift;
  logic [11:0] r_bcd;
  logic [1:0]  r_idx;
  logic        r_pend_valid;
  logic [7:0]  r_pend_data;
  logic        r_pend_hex;
  logic [6:0]  r_segments;
  logic        r_dp;

  state_t      w_state_next;
  logic [23:0] w_cnt_next;
  logic [1:0]  w_idx_next;
  logic        w_start;
  logic [7:0]  w_start_data;
  logic        w_start_hex;
  logic        w_pend_valid_next;
  logic [7:0]  w_pend_data_next;
  logic        w_pend_hex_next;
  logic [11:0] w_bcd_adj;
  logic [11:0] w_bcd_next;
  logic [7:0]  w_shift_next;
  logic [7:0]  w_value_next;
  logic        w_hex_next;
  logic [1:0]  w_ndig;
  logic [1:0]  w_ndig_next;
  logic [3:0]  w_digit_next;
  logic [6:0]  w_segments_next;
  logic        w_dp_next;
  logic        w_cnt_zero;
  logic        w_boundary;

  // Number of digits shown: hex always 2, decimal drops leading zeros.
  function automatic logic [1:0] ndig_of(input logic [11:0] bcd, input logic hex);
    if (hex)                    return 2'd2;
    else if (bcd[11:8] != 4'd0) return 2'd3;
    else if (bcd[7:4] != 4'd0)  return 2'd2;
    else                        return 2'd1;
  endfunction

  // Digit at position idx of the displayed list (idx 0 = most significant shown).
  function automatic logic [3:0] digit_of(input logic [11:0] bcd, input logic hex,
                                          input logic [7:0] val, input logic [1:0] idx,
                                          input logic [1:0] ndig);
    logic [1:0] pos;
    pos = ndig - 2'd1 - idx;
    if (hex) return (idx == 2'd0) ? val[7:4] : val[3:0];
    case (pos)
      2'd2:    return bcd[11:8];
      2'd1:    return bcd[7:4];
      default: return bcd[3:0];
    endcase
  endfunction

  function automatic logic [6:0] font(input logic [3:0] d);
    case (d)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Add-3 correction on each BCD nibble before the next shift.
  for (genvar gi = 0; gi < 3; gi++) begin : g_add3
    assign w_bcd_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ? r_bcd[gi*4 +: 4] + 4'd3
                                                              : r_bcd[gi*4 +: 4];
  end

  assign w_cnt_zero = (r_cnt == 24'd0);
  assign w_boundary = w_cnt_zero && ((r_state == S_GAP) ||
                                     (r_state == S_SHOW && GAP_CYCLES == 24'd0));
  assign w_ndig     = ndig_of(r_bcd, r_hex);

  // Next state, digit index, conversion start and pending-register update.
  always_comb begin
    w_state_next      = r_state;
    w_idx_next        = r_idx;
    w_start           = 1'b0;
    w_start_data      = i_out_data;
    w_start_hex       = i_hex_mode;
    w_pend_valid_next = r_pend_valid;
    w_pend_data_next  = r_pend_data;
    w_pend_hex_next   = r_pend_hex;
    case (r_state)
      S_IDLE:    if (i_out_valid) w_start = 1'b1;
      S_CONVERT: if (w_cnt_zero) begin
                   w_state_next = S_SHOW;
                   w_idx_next   = 2'd0;
                 end
      S_SHOW:    if (w_cnt_zero && GAP_CYCLES != 24'd0) w_state_next = S_GAP;
      default:   ;
    endcase
    if (w_boundary) begin
      if (i_out_valid) begin
        // A strobe coinciding with the boundary wins outright.
        w_start           = 1'b1;
        w_pend_valid_next = 1'b0;
      end else if (r_pend_valid) begin
        w_start           = 1'b1;
        w_start_data      = r_pend_data;
        w_start_hex       = r_pend_hex;
        w_pend_valid_next = 1'b0;
      end else begin
        w_state_next = S_SHOW;
        w_idx_next   = (r_idx == w_ndig - 2'd1) ? 2'd0 : r_idx + 2'd1;
      end
    end else if (i_out_valid && r_state != S_IDLE) begin
      w_pend_valid_next = 1'b1;
      w_pend_data_next  = i_out_data;
      w_pend_hex_next   = i_hex_mode;
    end
    if (w_start) w_state_next = S_CONVERT;
  end

  // Prescaler reload on every state entry (every exit happens at zero), else count down.
  always_comb begin
    w_cnt_next = r_cnt - 24'd1;
    if (r_state == S_IDLE || w_cnt_zero) begin
      case (w_state_next)
        S_CONVERT: w_cnt_next = 24'd7;
        S_SHOW:    w_cnt_next = DIGIT_CYCLES - 24'd1;
        S_GAP:     w_cnt_next = GAP_CYCLES - 24'd1;
        default:   w_cnt_next = 24'd0;
      endcase
    end
  end

  // Value latch and one double-dabble step per CONVERT cycle.
  always_comb begin
    w_value_next = r_value;
    w_hex_next   = r_hex;
    w_shift_next = r_shift;
    w_bcd_next   = r_bcd;
    if (w_start) begin
      w_value_next = w_start_data;
      w_hex_next   = w_start_hex;
      w_shift_next = w_start_data;
      w_bcd_next   = 12'd0;
    end else if (r_state == S_CONVERT) begin
      w_bcd_next   = {w_bcd_adj[10:0], r_shift[7]};
      w_shift_next = {r_shift[6:0], 1'b0};
    end
  end

  // Segment/dp values for the coming cycle, so the outputs stay registered.
  always_comb begin
    w_ndig_next     = ndig_of(w_bcd_next, w_hex_next);
    w_digit_next    = digit_of(w_bcd_next, w_hex_next, w_value_next, w_idx_next, w_ndig_next);
    w_segments_next = 7'd0;
    w_dp_next       = 1'b0;
    if (w_state_next == S_SHOW) begin
      w_segments_next = font(w_digit_next);
      w_dp_next       = (w_idx_next == w_ndig_next - 2'd1);
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= 24'd0;
      r_value      <= 8'd0;
      r_hex        <= 1'b0;
      r_shift      <= 8'd0;
      r_bcd        <= 12'd0;
      r_idx        <= 2'd0;
      r_pend_valid <= 1'b0;
      r_pend_data  <= 8'd0;
      r_pend_hex   <= 1'b0;
      r_segments   <= 7'd0;
      r_dp         <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_value      <= w_value_next;
      r_hex        <= w_hex_next;
      r_shift      <= w_shift_next;
      r_bcd        <= w_bcd_next;
      r_idx        <= w_idx_next;
      r_pend_valid <= w_pend_valid_next;
      r_pend_data  <= w_pend_data_next;
      r_pend_hex   <= w_pend_hex_next;
      r_segments   <= w_segments_next;
      r_dp         <= w_dp_next;
    end
  end

  assign o_segments = r_segments;
  assign o_dp       = r_dp;
  assign o_busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_jrb8_seg7_display.sv
// Directed bench for jrb8_seg7_display: each strobe pushes the expected
// per-cycle {busy, dp, segments} trace into a scoreboard queue, which is
// popped and compared every cycle on the falling clock edge.
module tb_jrb8_seg7_display;

  localparam int D = 4;
  localparam int G = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       v, hx, v0, hx0;
  logic [7:0] d, d0;
  logic [6:0] seg, seg0;
  logic       dp, busy, dp0, busy0;

  always #5 clk = ~clk;

  jrb8_seg7_display #(.DIGIT_CYCLES(24'd4), .GAP_CYCLES(24'd2)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_out_valid(v), .i_out_data(d), .i_hex_mode(hx),
    .o_segments(seg), .o_dp(dp), .o_busy(busy));

  jrb8_seg7_display #(.DIGIT_CYCLES(24'd4), .GAP_CYCLES(24'd0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_out_valid(v0), .i_out_data(d0), .i_hex_mode(hx0),
    .o_segments(seg0), .o_dp(dp0), .o_busy(busy0));

  logic [6:0] font_m [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic [8:0] exp_q [$];
  int         checks = 0;
  int         errors = 0;
  bit         sel0 = 1'b0;
  string      tag = "idle";

  function automatic int ndig_m(input int val, input bit hex);
    if (hex) return 2;
    if (val >= 100) return 3;
    if (val >= 10) return 2;
    return 1;
  endfunction

  function automatic int digit_m(input int val, input bit hex, input int i);
    int p;
    int dv;
    if (hex) return (i == 0) ? (val / 16) : (val % 16);
    p  = ndig_m(val, hex) - 1 - i;
    dv = (p == 2) ? 100 : (p == 1) ? 10 : 1;
    return (val / dv) % 10;
  endfunction

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(9'h000);
  endtask

  task automatic push_conv();
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, 1'b0, 7'h00});
  endtask

  task automatic push_show(input int val, input bit hex, input int i, input int n);
    logic last;
    last = (i == ndig_m(val, hex) - 1);
    for (int k = 0; k < n; k++) exp_q.push_back({1'b1, last, font_m[digit_m(val, hex, i)]});
  endtask

  task automatic push_period(input int val, input bit hex, input int gap);
    for (int i = 0; i < ndig_m(val, hex); i++) begin
      push_show(val, hex, i, D);
      for (int k = 0; k < gap; k++) exp_q.push_back({1'b1, 1'b0, 7'h00});
    end
  endtask

  task automatic pop_check();
    logic [8:0] o;
    logic [8:0] e;
    @(negedge clk);
    v  = 1'b0;
    v0 = 1'b0;
    o  = sel0 ? {busy0, dp0, seg0} : {busy, dp, seg};
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL %s scoreboard empty observed=%h", tag, o);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      assert (o === e) else begin
        errors++;
        $error("FAIL %s {busy,dp,seg} observed=%h expected=%h", tag, o, e);
      end
    end
  endtask

  task automatic drain_n(input int n);
    for (int i = 0; i < n; i++) pop_check();
  endtask

  task automatic drain();
    int n;
    n = exp_q.size();
    drain_n(n);
  endtask

  task automatic strobe(input logic [7:0] val, input bit hex);
    v  = 1'b1;
    d  = val;
    hx = hex;
    $display("strobe dut=gap%0d data=%02h hex=%0d", G, val, hex);
  endtask

  task automatic strobe0(input logic [7:0] val, input bit hex);
    v0  = 1'b1;
    d0  = val;
    hx0 = hex;
    $display("strobe dut=gap0 data=%02h hex=%0d", val, hex);
  endtask

  task automatic check_zero(input string t);
    checks++;
    assert ({busy, dp, seg} === 9'h000) else begin
      errors++;
      $error("FAIL %s dut observed=%h expected=000", t, {busy, dp, seg});
    end
    checks++;
    assert ({busy0, dp0, seg0} === 9'h000) else begin
      errors++;
      $error("FAIL %s dut0 observed=%h expected=000", t, {busy0, dp0, seg0});
    end
  endtask

  // Show one cycle of the first digit, then drop reset mid-cycle and confirm idle.
  task automatic reset_mid_show(input int val, input bit hex);
    push_show(val, hex, 0, 1);
    drain();
    #1 rst_n = 1'b0;
    #1 check_zero({tag, "_async_reset"});
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset pulse after %s", tag);
    tag = {tag, "_after_reset"};
    push_idle(4);
    drain();
  endtask

  int         vals [5] = '{7, 0, 255, 8'hA5, 8'h0F};
  bit         hexs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    v = 1'b0; hx = 1'b0; d = 8'd0;
    v0 = 1'b0; hx0 = 1'b0; d0 = 8'd0;
    #1 check_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    tag = "idle_after_release";
    push_idle(3);
    drain();

    // Decimal 123: two full periods, then reset mid-SHOW.
    tag = "dec123";
    strobe(8'd123, 1'b0);
    push_conv();
    push_period(123, 1'b0, G);
    push_period(123, 1'b0, G);
    drain();
    reset_mid_show(123, 1'b0);

    // Leading-zero suppression and hex mode.
    for (int s = 0; s < 5; s++) begin
      tag = $sformatf("val%02h_hex%0d", vals[s], hexs[s]);
      strobe(vals[s][7:0], hexs[s]);
      push_conv();
      push_period(vals[s], hexs[s], G);
      push_period(vals[s], hexs[s], G);
      drain();
      reset_mid_show(vals[s], hexs[s]);
    end

    // Pending: 45 then 67 arrive while "1" shows; only 67 is displayed.
    tag = "pending";
    strobe(8'd123, 1'b0);
    push_conv();
    push_show(123, 1'b0, 0, D);
    push_idle(0);
    for (int k = 0; k < G; k++) exp_q.push_back({1'b1, 1'b0, 7'h00});
    push_conv();
    push_period(67, 1'b0, G);
    push_period(67, 1'b0, G);
    drain_n(9);
    strobe(8'd45, 1'b0);
    drain_n(1);
    strobe(8'd67, 1'b0);
    drain();
    reset_mid_show(67, 1'b0);

    // GAP_CYCLES=0: strobe in the last SHOW cycle is taken at that boundary.
    sel0 = 1'b1;
    tag = "gap0_collision";
    strobe0(8'd7, 1'b0);
    push_conv();
    push_period(7, 1'b0, 0);
    push_conv();
    push_period(8'h3C, 1'b1, 0);
    push_period(8'h3C, 1'b1, 0);
    drain_n(12);
    strobe0(8'h3C, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
